// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Struct widths follow the package AW/DW defaults.
package regfile_pkg;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } rf_wr_t;

    // A single requester still needs a one-bit pointer.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back requester bundle: per-requester valid/ready plus packed addr/data, and a global hold.
interface regfile_wb_if #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               hold;

    modport master (output req_valid, req_addr, req_data, hold, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, hold, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr (mod NREQ) wins.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int PW  = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx
);

    logic found;
    int   slot;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        slot    = 0;
        for (int k = 0; k < NREQ; k++) begin
            slot = int'(ptr) + k;
            if (slot >= NREQ) slot = slot - NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (en && !found && req[i] && (slot == i)) begin
                    gnt[i]  = 1'b1;
                    gnt_idx = PW'(i);
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between NREQ write-back requesters, with RAW hazard
// handling on the two read ports. Define RF_WB_BYPASS_EN to forward instead of stalling.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = regfile_pkg::AW,
    parameter int DW   = regfile_pkg::DW,
    parameter int CW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_wb_if.slave   wb,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_wdata,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,
    output logic [DW-1:0] rd_data1,
    output logic [DW-1:0] rd_data2,
    output logic          rd_stall1,
    output logic          rd_stall2,
    output logic [CW-1:0] contention
);

    localparam int PW = ptr_w(NREQ);

    logic [PW-1:0]   ptr_q, ptr_d;
    rf_wr_t          wr_q, wr_d;
    logic [CW-1:0]   contention_q, contention_d;
    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    wb_req_t         sel;
    logic            hazard1, hazard2;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (wb.req_valid),
        .en      (!wb.hold),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign wb.req_ready = gnt;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel.addr = wb.req_addr[i*AW +: AW];
                sel.data = wb.req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        ptr_d        = ptr_q;
        wr_d         = wr_q;
        wr_d.we      = 1'b0;
        contention_d = contention_q;
        if (|gnt) begin
            ptr_d      = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            // Writes to $zero are accepted but never reach the register file.
            wr_d.we    = (sel.addr != REG_ZERO);
            wr_d.addr  = sel.addr;
            wr_d.wdata = sel.data;
        end
        if (!wb.hold && ($countones(wb.req_valid) > 1) && (contention_q != '1))
            contention_d = contention_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            wr_q         <= '0;
            contention_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            wr_q         <= wr_d;
            contention_q <= contention_d;
        end
    end

    assign rf_we      = wr_q.we;
    assign rf_addr    = wr_q.addr;
    assign rf_wdata   = wr_q.wdata;
    assign contention = contention_q;

    assign hazard1 = wr_q.we && (wr_q.addr == rd_addr1) && (rd_addr1 != REG_ZERO);
    assign hazard2 = wr_q.we && (wr_q.addr == rd_addr2) && (rd_addr2 != REG_ZERO);

`ifdef RF_WB_BYPASS_EN
    assign rd_data1  = hazard1 ? wr_q.wdata : rf_rd1;
    assign rd_data2  = hazard2 ? wr_q.wdata : rf_rd2;
    assign rd_stall1 = 1'b0;
    assign rd_stall2 = 1'b0;
`else
    // The register file has not committed yet, so the raw read is stale: retry next cycle.
    assign rd_data1  = rf_rd1;
    assign rd_data2  = rf_rd2;
    assign rd_stall1 = hazard1;
    assign rd_stall2 = hazard2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; expectations follow RF_WB_BYPASS_EN.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int CW   = 4;

    logic          clk;
    logic          rst_n;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic [DW-1:0] rf_rd1, rf_rd2;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          rd_stall1, rd_stall2;
    logic [CW-1:0] contention;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] t2_addr [4] = '{5'd3, 5'd10, 5'd11, 5'd10};
    logic [DW-1:0] t2_data [4] = '{32'h33, 32'h100, 32'h111, 32'h100};

    regfile_wb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) wb_if ();

    regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb         (wb_if),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_wdata   (rf_wdata),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rf_rd1     (rf_rd1),
        .rf_rd2     (rf_rd2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .rd_stall1  (rd_stall1),
        .rd_stall2  (rd_stall2),
        .contention (contention)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requesters may not withdraw a pending request.
    logic [NREQ-1:0] pend_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                assert (!pend_q[i] || wb_if.req_valid[i])
                    else $error("requester %0d dropped valid before transfer", i);
            pend_q <= wb_if.req_valid & ~wb_if.req_ready;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                           input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic h);
        wb_if.req_valid = v;
        wb_if.req_addr  = {a1, a0};
        wb_if.req_data  = {d1, d0};
        wb_if.hold      = h;
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr1 = '0; rd_addr2 = '0; rf_rd1 = '0; rf_rd2 = '0;
        set_req(2'b00, 0, 0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", rf_we, 0);
        chk("rst_addr", rf_addr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_cont", contention, 0);
        rst_n = 1'b1;
        #4;
        chk("idle_ready", wb_if.req_ready, 0);
        next_cycle();

        // single requester
        set_req(2'b01, 5'd5, 32'hDEADBEEF, 0, 0, 1'b0);
        #4;
        chk("t1_ready", wb_if.req_ready, 2'b01);
        chk("t1_we_pre", rf_we, 0);
        next_cycle();
        set_req(2'b00, 0, 0, 0, 0, 1'b0);
        #4;
        chk("t1_we", rf_we, 1);
        chk("t1_addr", rf_addr, 5);
        chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
        chk("t1_ready_idle", wb_if.req_ready, 0);
        next_cycle();
        #4;
        chk("t1_we_off", rf_we, 0);
        chk("t1_addr_hold", rf_addr, 5);
        chk("t1_wdata_hold", rf_wdata, 32'hDEADBEEF);
        next_cycle();

        // ptr is 1: let req1 go so both-valid starts at ptr 0
        set_req(2'b10, 0, 0, 5'd3, 32'h33, 1'b0);
        #4;
        chk("t2_pre_ready", wb_if.req_ready, 2'b10);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            set_req(2'b11, 5'd10, 32'h100, 5'd11, 32'h111, 1'b0);
            #4;
            chk("t2_ready", wb_if.req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("t2_we", rf_we, 1);
            chk("t2_addr", rf_addr, t2_addr[i]);
            chk("t2_wdata", rf_wdata, t2_data[i]);
            next_cycle();
        end
        set_req(2'b01, 5'd10, 32'h100, 5'd11, 32'h111, 1'b0);
        #4;
        chk("t2_tail_ready", wb_if.req_ready, 2'b01);
        chk("t2_tail_addr", rf_addr, 11);
        chk("t2_cont", contention, 4);
        next_cycle();
        set_req(2'b00, 0, 0, 0, 0, 1'b0);
        #4;
        chk("t2_last_addr", rf_addr, 10);
        chk("t2_last_wdata", rf_wdata, 32'h100);
        chk("t2_cont_hold", contention, 4);
        next_cycle();

        // write to $zero from req1 (ptr is 1)
        set_req(2'b10, 0, 0, 5'd0, 32'h5555, 1'b0);
        #4;
        chk("t3_ready", wb_if.req_ready, 2'b10);
        next_cycle();
        set_req(2'b11, 5'd12, 32'h1200, 5'd13, 32'h1300, 1'b0);
        #4;
        chk("t3_we_zero", rf_we, 0);
        chk("t3_ptr0", wb_if.req_ready, 2'b01);
        next_cycle();
        set_req(2'b10, 5'd12, 32'h1200, 5'd13, 32'h1300, 1'b0);
        #4;
        chk("t3_ready1", wb_if.req_ready, 2'b10);
        chk("t3_addr", rf_addr, 12);
        chk("t3_cont", contention, 5);
        next_cycle();
        set_req(2'b00, 0, 0, 0, 0, 1'b0);
        #4;
        chk("t3_addr2", rf_addr, 13);
        chk("t3_we2", rf_we, 1);
        next_cycle();

        // read-after-write hazard on r7
        set_req(2'b01, 5'd7, 32'h1234, 0, 0, 1'b0);
        rd_addr1 = 5'd7; rf_rd1 = 32'hAAAA; rd_addr2 = 5'd0; rf_rd2 = 32'hBBBB;
        #4;
        chk("t4_ready", wb_if.req_ready, 2'b01);
        chk("t4_pre_stall1", rd_stall1, 0);
        chk("t4_pre_data1", rd_data1, 32'hAAAA);
        next_cycle();
        set_req(2'b00, 0, 0, 0, 0, 1'b0);
        #4;
        chk("t4_we", rf_we, 1);
        chk("t4_addr", rf_addr, 7);
`ifdef RF_WB_BYPASS_EN
        chk("t4_stall1", rd_stall1, 0);
        chk("t4_data1", rd_data1, 32'h1234);
`else
        chk("t4_stall1", rd_stall1, 1);
        chk("t4_data1", rd_data1, 32'hAAAA);
`endif
        chk("t4_stall2_zero", rd_stall2, 0);
        chk("t4_data2_zero", rd_data2, 32'hBBBB);
        rd_addr2 = 5'd7;
        #1;
`ifdef RF_WB_BYPASS_EN
        chk("t4_stall2", rd_stall2, 0);
        chk("t4_data2", rd_data2, 32'h1234);
`else
        chk("t4_stall2", rd_stall2, 1);
        chk("t4_data2", rd_data2, 32'hBBBB);
`endif
        rd_addr1 = 5'd8;
        #1;
        chk("t4_miss_stall1", rd_stall1, 0);
        chk("t4_miss_data1", rd_data1, 32'hAAAA);
        next_cycle();
        rd_addr1 = 5'd7;
        #4;
        chk("t4_after_stall1", rd_stall1, 0);
        next_cycle();
        rd_addr1 = '0; rd_addr2 = '0;

        // hold with a write in flight (ptr is 1)
        set_req(2'b10, 0, 0, 5'd9, 32'h99, 1'b0);
        #4;
        chk("t5_pre_ready", wb_if.req_ready, 2'b10);
        next_cycle();
        for (int j = 0; j < 3; j++) begin
            set_req(2'b11, 5'd20, 32'h2000, 5'd21, 32'h2100, 1'b1);
            #4;
            chk("t5_ready", wb_if.req_ready, 0);
            chk("t5_we", rf_we, (j == 0) ? 1 : 0);
            chk("t5_cont", contention, 5);
            if (j == 0) begin
                chk("t5_addr", rf_addr, 9);
                chk("t5_wdata", rf_wdata, 32'h99);
            end
            next_cycle();
        end
        set_req(2'b11, 5'd20, 32'h2000, 5'd21, 32'h2100, 1'b0);
        #4;
        chk("t5_release_ready", wb_if.req_ready, 2'b01);
        chk("t5_release_cont", contention, 5);
        next_cycle();
        set_req(2'b10, 5'd20, 32'h2000, 5'd21, 32'h2100, 1'b0);
        #4;
        chk("t5_ready1", wb_if.req_ready, 2'b10);
        chk("t5_addr20", rf_addr, 20);
        chk("t5_cont6", contention, 6);
        next_cycle();
        set_req(2'b00, 0, 0, 0, 0, 1'b0);
        #4;
        chk("t5_addr21", rf_addr, 21);
        chk("t5_wdata21", rf_wdata, 32'h2100);
        next_cycle();

        // reset while a write is registered (ptr is 0, advances to 1)
        set_req(2'b01, 5'd15, 32'h1515, 0, 0, 1'b0);
        #4;
        chk("t6_ready", wb_if.req_ready, 2'b01);
        next_cycle();
        set_req(2'b00, 0, 0, 0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we", rf_we, 0);
        chk("t6_rst_addr", rf_addr, 0);
        chk("t6_rst_wdata", rf_wdata, 0);
        chk("t6_rst_cont", contention, 0);
        next_cycle();
        rst_n = 1'b1;
        #4;
        chk("t6_post_we", rf_we, 0);
        next_cycle();
        set_req(2'b11, 5'd16, 32'h1600, 5'd17, 32'h1700, 1'b0);
        #4;
        chk("t6_ptr0", wb_if.req_ready, 2'b01);
        chk("t6_no_stale", rf_we, 0);
        next_cycle();
        set_req(2'b10, 5'd16, 32'h1600, 5'd17, 32'h1700, 1'b0);
        #4;
        chk("t6_ready1", wb_if.req_ready, 2'b10);
        chk("t6_addr", rf_addr, 16);
        chk("t6_cont", contention, 1);
        next_cycle();

        // contention saturation at 2^CW-1
        for (int i = 0; i < 20; i++) begin
            set_req(2'b11, 5'd18, 32'h1800, 5'd19, 32'h1900, 1'b0);
            #4;
            chk("t7_ready", wb_if.req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("t7_cont", contention, (1 + i > 15) ? 15 : 1 + i);
            next_cycle();
        end
        set_req(2'b01, 5'd18, 32'h1800, 5'd19, 32'h1900, 1'b0);
        #4;
        chk("t7_tail_ready", wb_if.req_ready, 2'b01);
        chk("t7_sat", contention, 15);
        next_cycle();
        set_req(2'b00, 0, 0, 0, 0, 1'b0);
        #4;
        chk("t7_sat_hold", contention, 15);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
